// File: rtl/cache_mem_responder.sv
// Memory-side responder for the set-associative cache: serves line fills
// with a modelled read latency and absorbs evictions through a one-entry
// writeback buffer into a word-addressed backing RAM.
module cache_mem_responder #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int READ_LATENCY   = 4,
    parameter int WRITE_LATENCY  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_miss,
    input  logic [ADDR_WIDTH-1:0] i_miss_addr,
    input  logic                  i_evict,
    input  logic [ADDR_WIDTH-1:0] i_evict_addr,
    input  logic [DATA_WIDTH-1:0] i_evict_data,
    output logic [DATA_WIDTH-1:0] o_memory_line,
    output logic                  o_memory_response,
    output logic                  o_busy,
    output logic                  o_evict_overflow,
    output logic [15:0]           o_fill_count,
    output logic [15:0]           o_wb_count
);

    localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam int CNT_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WB   = 3'd1,
        S_RD   = 3'd2,
        S_RESP = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CNT_W-1:0]          r_rcnt;
    logic [CNT_W-1:0]          r_wcnt;
    logic [ADDR_WIDTH-1:0]     r_fill_addr;
    logic                      r_fill_lat;
    logic                      r_ev_valid;
    logic [MEM_DEPTH_LOG2-1:0] r_ev_idx;
    logic [DATA_WIDTH-1:0]     r_ev_data;
    logic [DATA_WIDTH-1:0]     r_line;
    logic                      r_resp;
    logic                      r_ovf;
    logic [15:0]               r_fill_cnt;
    logic [15:0]               r_wb_cnt;

    logic                      w_accept_miss;
    logic                      w_wb_start;
    logic                      w_wb_done;
    logic                      w_rd_start;
    logic                      w_rd_done;
    logic                      w_ev_space;
    logic [MEM_DEPTH_LOG2-1:0] w_fill_idx;
    logic [MEM_DEPTH_LOG2-1:0] w_ev_idx_in;
    logic [DATA_WIDTH-1:0]     w_mem [0:MEM_DEPTH-1];
    logic                      w_unused_evict_bits;

    assign w_fill_idx  = r_fill_addr[MEM_DEPTH_LOG2+1:2];
    assign w_ev_idx_in = i_evict_addr[MEM_DEPTH_LOG2+1:2];
    // Upper address bits alias and byte-offset bits are irrelevant to a word RAM.
    assign w_unused_evict_bits = ^{i_evict_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2+2], i_evict_addr[1:0]};

    // The buffer may refill on the same edge that its writeback completes.
    assign w_ev_space = !r_ev_valid || w_wb_done;

    // Backing RAM: one register per word, preloaded with its own index and never touched by reset.
    for (genvar g = 0; g < MEM_DEPTH; g++) begin : g_word
        logic [DATA_WIDTH-1:0] r_word = DATA_WIDTH'(g);
        // Commit the buffered eviction when its writeback completes.
        always_ff @(posedge clk) begin
            if (w_wb_done && (r_ev_idx == MEM_DEPTH_LOG2'(g))) begin
                r_word <= r_ev_data;
            end
        end
        assign w_mem[g] = r_word;
    end

    // Next-state logic; a pending writeback outranks a new fill in IDLE.
    always_comb begin
        w_state_nxt   = r_state;
        w_accept_miss = 1'b0;
        w_wb_start    = 1'b0;
        w_wb_done     = 1'b0;
        w_rd_start    = 1'b0;
        w_rd_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_ev_valid) begin
                    w_state_nxt   = S_WB;
                    w_wb_start    = 1'b1;
                    w_accept_miss = i_miss;
                end else if (i_miss) begin
                    w_state_nxt   = S_RD;
                    w_accept_miss = 1'b1;
                    w_rd_start    = 1'b1;
                end else begin
                    w_state_nxt   = S_IDLE;
                end
            end
            S_WB: begin
                if (r_wcnt == CNT_W'(0)) begin
                    w_wb_done = 1'b1;
                    if (r_fill_lat) begin
                        w_state_nxt = S_RD;
                        w_rd_start  = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_RD: begin
                if (r_rcnt == CNT_W'(0)) begin
                    w_state_nxt = S_RESP;
                    w_rd_done   = 1'b1;
                end else begin
                    w_state_nxt = S_RD;
                end
            end
            S_RESP: begin
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!i_miss || (i_miss_addr != r_fill_addr)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and latency counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rcnt  <= CNT_W'(0);
            r_wcnt  <= CNT_W'(0);
        end else begin
            r_state <= w_state_nxt;
            if (w_wb_start) begin
                r_wcnt <= CNT_W'(WRITE_LATENCY - 1);
            end else if ((r_state == S_WB) && (r_wcnt != CNT_W'(0))) begin
                r_wcnt <= r_wcnt - CNT_W'(1);
            end
            if (w_rd_start) begin
                r_rcnt <= CNT_W'(READ_LATENCY - 1);
            end else if ((r_state == S_RD) && (r_rcnt != CNT_W'(0))) begin
                r_rcnt <= r_rcnt - CNT_W'(1);
            end
        end
    end

    // Fill request latch; r_fill_lat marks a fill parked behind a writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill_addr <= {ADDR_WIDTH{1'b0}};
            r_fill_lat  <= 1'b0;
        end else begin
            if (w_accept_miss) begin
                r_fill_addr <= i_miss_addr;
            end
            if (w_rd_start) begin
                r_fill_lat <= 1'b0;
            end else if (w_accept_miss) begin
                r_fill_lat <= 1'b1;
            end
        end
    end

    // One-entry eviction buffer with sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ev_valid <= 1'b0;
            r_ev_idx   <= {MEM_DEPTH_LOG2{1'b0}};
            r_ev_data  <= {DATA_WIDTH{1'b0}};
            r_ovf      <= 1'b0;
        end else begin
            if (i_evict && w_ev_space) begin
                r_ev_valid <= 1'b1;
                r_ev_idx   <= w_ev_idx_in;
                r_ev_data  <= i_evict_data;
            end else if (w_wb_done) begin
                r_ev_valid <= 1'b0;
            end
            if (i_evict && !w_ev_space) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Fill data, response strobe and completion counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_line     <= {DATA_WIDTH{1'b0}};
            r_resp     <= 1'b0;
            r_fill_cnt <= 16'd0;
            r_wb_cnt   <= 16'd0;
        end else begin
            r_resp <= w_rd_done;
            if (w_rd_done) begin
                r_line <= w_mem[w_fill_idx];
            end
            if (r_state == S_RESP) begin
                r_fill_cnt <= r_fill_cnt + 16'd1;
            end
            if (w_wb_done) begin
                r_wb_cnt <= r_wb_cnt + 16'd1;
            end
        end
    end

    assign o_memory_line     = r_line;
    assign o_memory_response = r_resp;
    assign o_busy            = (r_state != S_IDLE) || r_ev_valid;
    assign o_evict_overflow  = r_ovf;
    assign o_fill_count      = r_fill_cnt;
    assign o_wb_count        = r_wb_cnt;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: each fill pushes its expected
// line and response cycle; a negedge monitor pops and compares on every
// response strobe.
module tb_cache_mem_responder;

    localparam int RL = 4;
    localparam int WL = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss;
    logic [31:0] i_miss_addr;
    logic        i_evict;
    logic [31:0] i_evict_addr;
    logic [31:0] i_evict_data;
    logic [31:0] o_memory_line;
    logic        o_memory_response;
    logic        o_busy;
    logic        o_evict_overflow;
    logic [15:0] o_fill_count;
    logic [15:0] o_wb_count;

    typedef struct {
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_total = 0;
    int   n_bad   = 0;

    cache_mem_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH_LOG2(10),
        .READ_LATENCY(RL), .WRITE_LATENCY(WL)
    ) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .i_evict(i_evict), .i_evict_addr(i_evict_addr), .i_evict_data(i_evict_data),
        .o_memory_line(o_memory_line), .o_memory_response(o_memory_response),
        .o_busy(o_busy), .o_evict_overflow(o_evict_overflow),
        .o_fill_count(o_fill_count), .o_wb_count(o_wb_count)
    );

    always #5 clk = ~clk;

    // Cycle counter: value after posedge k is k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    // Response monitor: pop expected entry and compare data and arrival cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && o_memory_response) begin
            if (sb.size() == 0) begin
                check_val("spurious_resp", {31'd0, o_memory_response}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_val("fill_data", o_memory_line, e.data);
                check_val("fill_cycle", cyc, e.at);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise a fill and record what should come back and when.
    task automatic fill(input logic [31:0] a, input logic [31:0] d, input int lat);
        i_miss      = 1'b1;
        i_miss_addr = a;
        sb.push_back('{d, cyc + lat});
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int i = 0; i < max_cyc && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check_val("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc && o_busy; i++) begin
            step();
        end
        check_val("idle_reached", {31'd0, o_busy}, 32'd0);
    endtask

    task automatic check_zero_outs(input string tag);
        check_val({tag, "_line"}, o_memory_line, 32'd0);
        check_val({tag, "_resp"}, {31'd0, o_memory_response}, 32'd0);
        check_val({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
        check_val({tag, "_ovf"}, {31'd0, o_evict_overflow}, 32'd0);
        check_val({tag, "_fcnt"}, {16'd0, o_fill_count}, 32'd0);
        check_val({tag, "_wcnt"}, {16'd0, o_wb_count}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        i_miss       = 1'b0;
        i_miss_addr  = 32'd0;
        i_evict      = 1'b0;
        i_evict_addr = 32'd0;
        i_evict_data = 32'd0;
        repeat (2) @(negedge clk);
        check_zero_outs("rst0");
        rst = 1'b0;

        // Plain fill: word 4 returns 4 exactly RL cycles after accept; held miss is not re-served.
        step();
        fill(32'h0000_0010, 32'h0000_0004, 1 + RL);
        wait_drain(20);
        repeat (8) step();
        check_val("hold_fcnt", {16'd0, o_fill_count}, 32'd1);
        check_val("hold_busy", {31'd0, o_busy}, 32'd1);
        i_miss = 1'b0;
        step();
        step();
        check_val("idle_busy", {31'd0, o_busy}, 32'd0);
        check_val("line_kept", o_memory_line, 32'h0000_0004);

        // Eviction then fill of the same word: writeback first, fill sees new data.
        step();
        i_evict      = 1'b1;
        i_evict_addr = 32'h0000_0040;
        i_evict_data = 32'hDEAD_BEEF;
        step();
        i_evict = 1'b0;
        fill(32'h0000_0040, 32'hDEAD_BEEF, 1 + WL + RL);
        repeat (3) step();
        check_val("wb_before_resp", {16'd0, o_wb_count}, 32'd1);
        check_val("no_resp_yet", {31'd0, o_memory_response}, 32'd0);
        wait_drain(30);
        i_miss = 1'b0;
        step();
        step();
        check_val("wbf_fcnt", {16'd0, o_fill_count}, 32'd2);

        // Two evictions back to back during RD: second is dropped and flagged.
        step();
        fill(32'h0000_0100, 32'h0000_0040, 1 + RL);
        step();
        i_evict      = 1'b1;
        i_evict_addr = 32'h0000_0080;
        i_evict_data = 32'hA5A5_0001;
        step();
        i_evict_data = 32'h5A5A_0002;
        step();
        i_evict = 1'b0;
        check_val("ovf_set", {31'd0, o_evict_overflow}, 32'd1);
        wait_drain(20);
        i_miss = 1'b0;
        wait_idle(30);
        check_val("ovf_wcnt", {16'd0, o_wb_count}, 32'd2);
        fill(32'h0000_0080, 32'hA5A5_0001, 1 + RL);
        wait_drain(20);
        i_miss = 1'b0;
        step();
        step();
        check_val("ovf_fcnt", {16'd0, o_fill_count}, 32'd4);

        // Back-to-back fills: address change while held high re-arms the responder.
        step();
        fill(32'h0000_0000, 32'h0000_0000, 1 + RL);
        wait_drain(20);
        step();
        fill(32'h0000_0004, 32'h0000_0001, 2 + RL);
        wait_drain(20);
        i_miss = 1'b0;
        step();
        step();
        check_val("b2b_fcnt", {16'd0, o_fill_count}, 32'd6);
        check_val("ovf_sticky", {31'd0, o_evict_overflow}, 32'd1);

        // Reset two cycles into a read: fill abandoned, everything cleared, RAM intact.
        step();
        i_miss      = 1'b1;
        i_miss_addr = 32'h0000_0008;
        step();
        step();
        step();
        #1;
        rst    = 1'b1;
        i_miss = 1'b0;
        #1;
        check_zero_outs("rst_mid");
        #10;
        rst = 1'b0;
        repeat (8) step();
        check_val("post_rst_busy", {31'd0, o_busy}, 32'd0);
        check_val("post_rst_fcnt", {16'd0, o_fill_count}, 32'd0);
        fill(32'h0000_0008, 32'h0000_0002, 1 + RL);
        wait_drain(20);
        i_miss = 1'b0;
        step();
        step();
        fill(32'h0000_0014, 32'h0000_0005, 1 + RL);
        wait_drain(20);
        i_miss = 1'b0;
        step();
        step();
        fill(32'h0000_0040, 32'hDEAD_BEEF, 1 + RL);
        wait_drain(20);
        i_miss = 1'b0;
        step();
        step();
        check_val("end_fcnt", {16'd0, o_fill_count}, 32'd3);
        check_val("end_wcnt", {16'd0, o_wb_count}, 32'd0);
        check_val("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
